// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
// Time-multiplexed driver for a 4-digit seven-segment display. New values are
// held in a pending shadow and copied to the display registers only at a frame
// boundary, so a digit never changes halfway through a frame. Each digit slot
// starts with a short all-off guard interval that keeps the previous digit's
// pattern from ghosting onto the next one.

module seg7_scan_driver #(
  parameter int SCAN_DIV       = 50000,
  parameter int BLANK_CYCLES   = 500,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit SEL_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en_i,
  input  logic        w_en_i,
  input  logic [15:0] value_i,
  input  logic [3:0]  dp_i,
  input  logic [3:0]  blank_i,
  output logic [7:0]  seg_o,
  output logic [3:0]  seg_sel_o,
  output logic        frame_o
);

  localparam int               CNT_W     = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_CNT = CNT_W'(BLANK_CYCLES);
  // The "off" level of each field doubles as the polarity mask: XOR with
  // all-ones inverts an active-high pattern, XOR with zero leaves it alone.
  localparam logic [7:0]       SEG_OFF   = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [3:0]       SEL_OFF   = SEL_ACTIVE_LOW ? 4'hF : 4'h0;

  logic [CNT_W-1:0] r_divCnt;
  logic [1:0]       r_digit;
  logic [15:0]      r_pendValue;
  logic [3:0]       r_pendDp;
  logic [3:0]       r_pendBlank;
  logic [15:0]      r_dispValue;
  logic [3:0]       r_dispDp;
  logic [3:0]       r_dispBlank;
  logic [7:0]       r_seg;
  logic [3:0]       r_sel;
  logic             r_frame;

  logic             w_slotEnd;
  logic             w_commit;
  logic             w_loadDisp;
  logic [15:0]      w_nextValue;
  logic [3:0]       w_nextDp;
  logic [3:0]       w_nextBlank;
  logic [3:0]       w_nibble;
  logic [6:0]       w_glyph;
  logic [7:0]       w_segAh;
  logic [3:0]       w_selAh;
  logic             w_lit;

  assign w_slotEnd = (r_divCnt == LAST_CNT);
  assign w_commit  = en_i && w_slotEnd && (r_digit == 2'd3);
  // While scanning is off the display simply tracks the pending data.
  assign w_loadDisp = !en_i || w_commit;

  // A write landing on the load cycle wins over the older pending contents.
  assign w_nextValue = w_en_i ? value_i : r_pendValue;
  assign w_nextDp    = w_en_i ? dp_i    : r_pendDp;
  assign w_nextBlank = w_en_i ? blank_i : r_pendBlank;

  assign w_nibble = r_dispValue[{r_digit, 2'b00} +: 4];
  assign w_segAh  = {r_dispDp[r_digit], w_glyph};
  assign w_selAh  = 4'b0001 << r_digit;
  assign w_lit    = en_i && (r_divCnt >= BLANK_CNT) && !r_dispBlank[r_digit];

  // Hex nibble to active-high segment pattern, bit order gfedcba.
  always_comb begin
    w_glyph = 7'h00;
    case (w_nibble)
      4'h0: w_glyph = 7'h3F;
      4'h1: w_glyph = 7'h06;
      4'h2: w_glyph = 7'h5B;
      4'h3: w_glyph = 7'h4F;
      4'h4: w_glyph = 7'h66;
      4'h5: w_glyph = 7'h6D;
      4'h6: w_glyph = 7'h7D;
      4'h7: w_glyph = 7'h07;
      4'h8: w_glyph = 7'h7F;
      4'h9: w_glyph = 7'h6F;
      4'hA: w_glyph = 7'h77;
      4'hB: w_glyph = 7'h7C;
      4'hC: w_glyph = 7'h39;
      4'hD: w_glyph = 7'h5E;
      4'hE: w_glyph = 7'h79;
      default: w_glyph = 7'h71;
    endcase
  end

  // Capture every host write into the pending shadow, whether or not we scan.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pendValue <= 16'h0000;
      r_pendDp    <= 4'h0;
      r_pendBlank <= 4'h0;
    end else if (w_en_i) begin
      r_pendValue <= value_i;
      r_pendDp    <= dp_i;
      r_pendBlank <= blank_i;
    end
  end

  // Slot divider and digit pointer; both park at zero while disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_divCnt <= '0;
      r_digit  <= 2'd0;
    end else if (!en_i) begin
      r_divCnt <= '0;
      r_digit  <= 2'd0;
    end else if (w_slotEnd) begin
      r_divCnt <= '0;
      r_digit  <= r_digit + 2'd1;
    end else begin
      r_divCnt <= r_divCnt + 1'b1;
    end
  end

  // Display registers load at the end of the digit-3 slot or continuously when off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dispValue <= 16'h0000;
      r_dispDp    <= 4'h0;
      r_dispBlank <= 4'h0;
    end else if (w_loadDisp) begin
      r_dispValue <= w_nextValue;
      r_dispDp    <= w_nextDp;
      r_dispBlank <= w_nextBlank;
    end
  end

  // Registered pin stage with guard interval, blanking and polarity applied last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg   <= SEG_OFF;
      r_sel   <= SEL_OFF;
      r_frame <= 1'b0;
    end else begin
      r_seg   <= w_lit ? (w_segAh ^ SEG_OFF) : SEG_OFF;
      r_sel   <= w_lit ? (w_selAh ^ SEL_OFF) : SEL_OFF;
      r_frame <= w_commit;
    end
  end

  assign seg_o     = r_seg;
  assign seg_sel_o = r_sel;
  assign frame_o   = r_frame;

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Time-multiplexed driver for the board's 4-digit seven-segment display. It sits directly downstream of the GPIO block's display register and produces the physical pin_seg / pin_seg_sel pins.
- Accepts a 16-bit hex value plus per-digit decimal-point and blank masks. Values are held in a pending shadow and committed only at a frame boundary, so a digit never tears mid-frame.
- Each digit slot opens with a short all-off guard interval to suppress ghosting.

Parameters:
- SCAN_DIV, 50000, clk cycles per digit slot; legal range ≥ 2.
- BLANK_CYCLES, 500, all-off guard cycles at the start of each slot; must be < SCAN_DIV.
- SEG_ACTIVE_LOW, 1, 1 = a lit segment drives 0.
- SEL_ACTIVE_LOW, 1, 1 = the selected digit drives 0.

Ports:
- clk  input  1  CPU clock.
- rst_n  input  1  asynchronous active-low reset.
- en_i  input  1  scan enable; low = display dark.
- w_en_i  input  1  single-cycle load strobe for value_i, dp_i and blank_i.
- value_i  input  16  hex digits; digit k = value_i[4k+3:4k].
- dp_i  input  4  decimal-point enable per digit.
- blank_i  input  4  force digit k dark.
- seg_o  output  8  [0]=a … [6]=g, [7]=dp.
- seg_sel_o  output  4  digit select; bit k = digit k (bit 0 is the rightmost digit).
- frame_o  output  1  one-cycle pulse on each commit.

Behaviour:
- Reset is asynchronous and active-low, on clk. On reset:
  - div_cnt = 0 and digit = 0.
  - The pending and display registers (value, dp, blank) = 0.
  - seg_o and seg_sel_o are all inactive: 8'hFF / 4'hF with the default polarity.
  - frame_o = 0.
- Pending capture: on any cycle with w_en_i = 1, pending ← {value_i, dp_i, blank_i}, regardless of en_i.
- Scan counter, when en_i = 1:
  - div_cnt increments each cycle.
  - At div_cnt == SCAN_DIV-1: div_cnt ← 0 and digit ← digit+1 mod 4, giving scan order 0,1,2,3,0.
- Commit:
  - Occurs on the cycle div_cnt == SCAN_DIV-1 with digit == 3: display ← pending, and frame_o is pulsed on the next cycle.
  - If w_en_i coincides with a commit, the display takes the incoming port data (newest wins), and pending updates as well.
- en_i = 0:
  - div_cnt and digit are held at 0.
  - display ← pending every cycle (transparent), and frame_o stays 0.
  - Outputs are all inactive from the next cycle onward.
- Re-enable: scanning restarts at digit 0, div_cnt 0.
- Output stage: registered, so outputs have 1-cycle latency from the (digit, div_cnt) state. In the next cycle:
  - If en_i && div_cnt ≥ BLANK_CYCLES && !display_blank[digit]:
    - seg_sel_o has only bit[digit] active.
    - seg_o[6:0] = decode(display nibble[digit]).
    - seg_o[7] = display_dp[digit].
  - Otherwise both seg_o and seg_sel_o are all inactive.
  - Polarity is applied last: an active-low field is the bitwise inverse of the active-high value.
- Active-high decode (gfedcba):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
- Exclusivity: at most one seg_sel_o bit is active in any cycle.
- Reset mid-scan: everything returns to reset values immediately; pending data is lost.
- Slot timing: a full frame is 4·SCAN_DIV cycles. Each digit is lit for SCAN_DIV − BLANK_CYCLES cycles per frame.

Test Plan:
- Commit timing. Configure SCAN_DIV=4, BLANK_CYCLES=1, polarity defaults. Drive w_en_i with value 16'h12AF, dp 4'b0000, blank 4'b0000 while en_i=1.
  - Old display continues until the digit-3 slot ends.
  - After the commit, the digit-0 slot shows sel=4'b1110, seg=~8'h71=8'h8E, then digit 1 shows seg=~8'h77=8'h88.
  - frame_o pulses exactly once per 16 cycles.
- Guard interval. In the first cycle of each slot (one cycle after the state, due to output latency), seg_o=8'hFF and seg_sel_o=4'hF. All 16 hex values map to the decode table above.
- Masks. Set dp_i=4'b0100 and blank_i=4'b1000.
  - Digit 2 shows seg_o[7]=0.
  - The digit-3 slot stays dark throughout: sel never equals 4'b0111.
- Disable and re-enable.
  - With en_i=0 for 10 cycles: all outputs are inactive and a w_en_i write is visible immediately on re-enable.
  - On re-enable, the first lit slot is digit 0 at cycle BLANK_CYCLES+1.
- Coincident write. Assert w_en_i on exactly the commit cycle with 16'hBEEF. The next frame displays BEEF, not the prior pending value.
- Async reset. Pull rst_n low mid-slot on digit 2.
  - Outputs go inactive without a clock edge.
  - After release, display=0000 and scanning restarts at digit 0.
